// File: rtl/fdn_pkg.sv
// Shared constants and types for the FDN delay-line scheduler.
package fdn_pkg;
  localparam int unsigned NLINES    = 4;
  localparam int unsigned LINE_W    = 2;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned SEG_W     = 12;
  localparam int unsigned DLY0_INIT = 1153;
  localparam int unsigned DLY1_INIT = 1499;
  localparam int unsigned DLY2_INIT = 2003;
  localparam int unsigned DLY3_INIT = 2711;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    CLEAR
  } state_t;
endpackage

// File: rtl/fdn_delay_cfg.sv
// Pending/active per-line delay banks; pending loads into active atomically on accept.
module fdn_delay_cfg #(
  parameter int unsigned SEG_W     = 12,
  parameter int unsigned DLY0_INIT = 1153,
  parameter int unsigned DLY1_INIT = 1499,
  parameter int unsigned DLY2_INIT = 2003,
  parameter int unsigned DLY3_INIT = 2711
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [SEG_W-1:0] cfg_delay,
  input  logic             load,
  input  logic [1:0]       rd_sel,
  input  logic             rd_pend,
  output logic [SEG_W-1:0] rd_dly_c
);
  import fdn_pkg::*;

  localparam logic [NLINES-1:0][SEG_W-1:0] DLY_RST = {
    SEG_W'(DLY3_INIT), SEG_W'(DLY2_INIT), SEG_W'(DLY1_INIT), SEG_W'(DLY0_INIT)
  };

  logic [NLINES-1:0][SEG_W-1:0] pending;
  logic [NLINES-1:0][SEG_W-1:0] active;

  // A zero delay would make the read hit the word being written; clamp to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= DLY_RST;
      active  <= DLY_RST;
    end else begin
      if (load) active <= pending;
      if (cfg_we) pending[cfg_sel] <= (cfg_delay == '0) ? SEG_W'(1) : cfg_delay;
    end
  end

  // On the accept cycle the delay about to become active is the pending one.
  always_comb begin
    rd_dly_c = active[rd_sel];
    if (rd_pend) rd_dly_c = pending[rd_sel];
  end
endmodule

// File: rtl/fdn_delay_scheduler.sv
// Time-multiplexes four FDN delay lines onto one shared simple-dual-port BRAM.
// Optional FDN_SCHED_CLEAR_EN: zero the whole BRAM after reset before going idle.
module fdn_delay_scheduler #(
  parameter int unsigned DATA_W    = fdn_pkg::DATA_W,
  parameter int unsigned SEG_W     = fdn_pkg::SEG_W,
  parameter int unsigned DLY0_INIT = fdn_pkg::DLY0_INIT,
  parameter int unsigned DLY1_INIT = fdn_pkg::DLY1_INIT,
  parameter int unsigned DLY2_INIT = fdn_pkg::DLY2_INIT,
  parameter int unsigned DLY3_INIT = fdn_pkg::DLY3_INIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic [4*DATA_W-1:0] fb_data,
  output logic [4*DATA_W-1:0] taps,
  output logic                taps_valid,
  output logic                busy,
  output logic                overrun,
  input  logic                overrun_clr,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic [SEG_W-1:0]    cfg_delay,
  output logic                ram_we,
  output logic [SEG_W+1:0]    ram_waddr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [SEG_W+1:0]    ram_raddr,
  input  logic [DATA_W-1:0]   ram_rdata
);
  import fdn_pkg::*;

  state_t                       state;
  line_t                        idx;
  logic [SEG_W-1:0]             wr_ptr;
  logic [NLINES-1:0][DATA_W-1:0] fb_lat;
  logic [NLINES-2:0][DATA_W-1:0] cap;
  logic [NLINES-1:0][DATA_W-1:0] fb_in;
`ifdef FDN_SCHED_CLEAR_EN
  logic [SEG_W+1:0]             clr_cnt;
`endif

  logic                         accept_c;
  line_t                        nxt_idx_c;
  logic [SEG_W-1:0]             nxt_dly_c;
  logic [DATA_W-1:0]            nxt_data_c;
  logic [SEG_W-1:0]             nxt_rptr_c;

  assign fb_in = fb_data;

  fdn_delay_cfg #(
    .SEG_W     (SEG_W),
    .DLY0_INIT (DLY0_INIT),
    .DLY1_INIT (DLY1_INIT),
    .DLY2_INIT (DLY2_INIT),
    .DLY3_INIT (DLY3_INIT)
  ) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_delay (cfg_delay),
    .load      (accept_c),
    .rd_sel    (nxt_idx_c),
    .rd_pend   (accept_c),
    .rd_dly_c  (nxt_dly_c)
  );

  // Address/data for the line slot that the next clock edge launches.
  always_comb begin
    accept_c   = (state == IDLE) && sample_strobe;
    nxt_idx_c  = accept_c ? line_t'(0) : idx + line_t'(1);
    nxt_data_c = accept_c ? fb_in[0] : fb_lat[nxt_idx_c];
    nxt_rptr_c = wr_ptr - nxt_dly_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef FDN_SCHED_CLEAR_EN
      state   <= CLEAR;
      clr_cnt <= '0;
`else
      state   <= IDLE;
`endif
      idx        <= '0;
      wr_ptr     <= '0;
      fb_lat     <= '0;
      cap        <= '0;
      taps       <= '0;
      taps_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_raddr  <= '0;
      ram_wdata  <= '0;
    end else begin
      taps_valid <= 1'b0;
      ram_we     <= 1'b0;

      if (sample_strobe && (state != IDLE)) overrun <= 1'b1;
      else if (overrun_clr)                 overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_strobe) begin
            fb_lat    <= fb_in;
            state     <= RUN;
            idx       <= nxt_idx_c;
            busy      <= 1'b1;
            ram_we    <= 1'b1;
            ram_waddr <= {nxt_idx_c, wr_ptr};
            ram_raddr <= {nxt_idx_c, nxt_rptr_c};
            ram_wdata <= nxt_data_c;
          end
        end
        RUN: begin
          // BRAM data for the previous slot's read address arrives now.
          if (idx != line_t'(0)) cap[idx - line_t'(1)] <= ram_rdata;
          if (idx == line_t'(NLINES - 1)) begin
            state <= DRAIN;
          end else begin
            idx       <= nxt_idx_c;
            ram_we    <= 1'b1;
            ram_waddr <= {nxt_idx_c, wr_ptr};
            ram_raddr <= {nxt_idx_c, nxt_rptr_c};
            ram_wdata <= nxt_data_c;
          end
        end
        DRAIN: begin
          taps       <= {ram_rdata, cap[2], cap[1], cap[0]};
          taps_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          wr_ptr <= wr_ptr + SEG_W'(1);
          busy   <= 1'b0;
          state  <= IDLE;
        end
`ifdef FDN_SCHED_CLEAR_EN
        CLEAR: begin
          ram_we    <= 1'b1;
          ram_waddr <= clr_cnt;
          ram_wdata <= '0;
          clr_cnt   <= clr_cnt + (SEG_W+2)'(1);
          if (clr_cnt == '1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            busy  <= 1'b1;
          end
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fdn_delay_scheduler.sv
// Randomized self-checking bench for fdn_delay_scheduler with a history-based tap model.
module tb_fdn_delay_scheduler;
  localparam int DW = 16;
  localparam int SW = 12;
  localparam int NL = 4;
  localparam int AW = SW + 2;
  localparam int HN = 8192;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_strobe = 1'b0;
  logic [NL*DW-1:0]  fb_data = '0;
  logic [NL*DW-1:0]  taps;
  logic              taps_valid;
  logic              busy;
  logic              overrun;
  logic              overrun_clr = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_sel = '0;
  logic [SW-1:0]     cfg_delay = '0;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DW-1:0]     ram_wdata;
  logic [AW-1:0]     ram_raddr;
  logic [DW-1:0]     ram_rdata;

  fdn_delay_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .fb_data       (fb_data),
    .taps          (taps),
    .taps_valid    (taps_valid),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .cfg_we        (cfg_we),
    .cfg_sel       (cfg_sel),
    .cfg_delay     (cfg_delay),
    .ram_we        (ram_we),
    .ram_waddr     (ram_waddr),
    .ram_wdata     (ram_wdata),
    .ram_raddr     (ram_raddr),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  // Simple-dual-port BRAM: synchronous write, registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  int checks = 0;
  int failures = 0;

  // Reference model: every accepted sample's words kept per line.
  logic [DW-1:0] hist [NL][HN];
  int n = 0;
  int mptr = 0;
  int act [NL];
  int pend [NL];
  bit m_ovr = 1'b0;

  int intr_at = -1;
  int clr_at = -1;
  bit cfg_now = 1'b0;
  int c_sel = 0;
  int c_dly = 0;
  bit chk_taps = 1'b1;
  int pat = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampd(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    act[0] = 1153; act[1] = 1499; act[2] = 2003; act[3] = 2711;
    for (int i = 0; i < NL; i++) pend[i] = act[i];
    mptr = 0;
    m_ovr = 1'b0;
  endtask

  task automatic wait_ready();
`ifdef FDN_SCHED_CLEAR_EN
    int c;
    c = 0;
    @(posedge clk); #1;
    while (busy && c < 20000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("clear_done", {127'd0, busy}, 128'd0);
    chk("clear_len", {127'd0, (c >= 16382 && c <= 16384)}, 128'd1);
`else
    @(posedge clk); #1;
`endif
  endtask

  task automatic cfg_write(input int sel, input int dly);
    cfg_we = 1'b1;
    cfg_sel = 2'(sel);
    cfg_delay = SW'(dly);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    pend[sel] = clampd(dly);
  endtask

  task automatic run_sample();
    logic [NL-1:0][DW-1:0] fb;
    logic [NL-1:0][DW-1:0] exp;
    int d [NL];
    for (int i = 0; i < NL; i++) begin
      if (pat == 0)                fb[i] = DW'(256 * i + n);
      else if (pat == 1 && i == 0) fb[i] = DW'(n);
      else                         fb[i] = DW'($urandom);
      act[i] = pend[i];
      d[i] = act[i];
      exp[i] = (n >= d[i]) ? hist[i][n - d[i]] : '0;
    end
    if (cfg_now) begin
      cfg_we = 1'b1;
      cfg_sel = 2'(c_sel);
      cfg_delay = SW'(c_dly);
      pend[c_sel] = clampd(c_dly);
    end
    fb_data = fb;
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    cfg_we = 1'b0;
    chk("busy_run", {127'd0, busy}, 128'd1);
    for (int k = 0; k < 6; k++) begin
      if (k < 4)
        chk($sformatf("ram_slot%0d_n%0d", k, n),
            {83'd0, ram_we, ram_waddr, ram_raddr, ram_wdata},
            {83'd0, 1'b1, 2'(k), SW'(mptr), 2'(k), SW'(mptr - d[k]), fb[k]});
      if (k < 5) begin
        chk($sformatf("tv_early_k%0d", k), {127'd0, taps_valid}, 128'd0);
      end else begin
        chk("tv_t6", {127'd0, taps_valid}, 128'd1);
        if (chk_taps) chk($sformatf("taps_n%0d", n), {64'd0, taps}, {64'd0, exp});
      end
      sample_strobe = (k == intr_at);
      overrun_clr = (k == clr_at);
      if (sample_strobe) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
      @(posedge clk); #1;
    end
    sample_strobe = 1'b0;
    overrun_clr = 1'b0;
    chk("tv_idle", {127'd0, taps_valid}, 128'd0);
    chk("busy_idle", {127'd0, busy}, 128'd0);
    chk("overrun", {127'd0, overrun}, {127'd0, m_ovr});
    for (int i = 0; i < NL; i++) hist[i][n] = fb[i];
    n++;
    mptr = (mptr + 1) % (1 << SW);
  endtask

  initial begin
    int tv_cnt;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {19'd0, taps, taps_valid, busy, overrun, ram_we, ram_waddr, ram_raddr, ram_wdata}, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    wait_ready();

    // Reset delays with a ramp on line 0.
    pat = 1;
    repeat (1201) run_sample();
    chk("tap0_at_1200", {112'd0, taps[15:0]}, 128'd47);

    // All delays 1: each tap equals the previous sample's word.
    for (int i = 0; i < NL; i++) cfg_write(i, 1);
    pat = 0;
    repeat (6) run_sample();
    chk("line2_prev", {112'd0, taps[47:32]}, {112'd0, 16'(512 + n - 2)});

    // Delay 3 across the write-pointer wrap.
    for (int i = 0; i < NL; i++) cfg_write(i, 3);
    pat = 2;
    while (n < 4200) run_sample();

    // Overrun: ignored strobe, then set/clear collision, then clear.
    intr_at = 2;
    run_sample();
    intr_at = 1; clr_at = 1;
    run_sample();
    intr_at = -1; clr_at = 0;
    run_sample();
    clr_at = -1;

    // Config write coincident with accept, delay 0 clamps to 1.
    cfg_now = 1'b1; c_sel = 2; c_dly = 0;
    run_sample();
    cfg_now = 1'b0;
    run_sample();
    chk("clamp_line2", {112'd0, taps[47:32]}, {112'd0, hist[2][n - 2]});

    // Reset in the middle of a sequence.
    fb_data = {$urandom, $urandom};
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("reset_async", {19'd0, taps, taps_valid, busy, overrun, ram_we, ram_waddr, ram_raddr, ram_wdata}, 128'd0);
    tv_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (taps_valid) tv_cnt++;
    end
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    repeat (5) begin
      @(posedge clk); #1;
      if (taps_valid) tv_cnt++;
    end
    chk("no_tv_after_abort", 128'(tv_cnt), 128'd0);
    wait_ready();
    chk_taps = 1'b0;
    run_sample();
`ifdef FDN_SCHED_CLEAR_EN
    chk("clear_taps_zero", {64'd0, taps}, 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fdn_delay_scheduler.md
Name: fdn_delay_scheduler

Overview:
Time-multiplexes the four FDN delay lines onto one shared simple-dual-port BRAM, so a single memory replaces four per-line RAM instances. Once per audio sample strobe, it sequences one read (tap) and one write (feedback) per line, then presents all four taps together. It sits between the Hadamard feedback matrix and the shared BRAM primitive, and owns the per-line delay configuration.

Parameters:
DATA_W, 16, sample width (signed, two's complement)
SEG_W, 12, address bits per line segment; each line holds 2^SEG_W words
DLY0_INIT, 1153, reset delay of line 0, in samples
DLY1_INIT, 1499, reset delay of line 1
DLY2_INIT, 2003, reset delay of line 2
DLY3_INIT, 2711, reset delay of line 3

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_strobe  in  1  one-cycle pulse, one per audio sample
fb_data  in  4*DATA_W  feedback words to write; line i at [i*DATA_W +: DATA_W]
taps  out  4*DATA_W  delayed words, same packing as fb_data
taps_valid  out  1  one-cycle pulse; taps updated
busy  out  1  sequence in progress
overrun  out  1  sticky; strobe arrived while busy
overrun_clr  in  1  clears overrun
cfg_we  in  1  delay config write
cfg_sel  in  2  line select
cfg_delay  in  SEG_W  requested delay in samples
ram_we  out  1  BRAM port A write enable
ram_waddr  out  SEG_W+2  write address {line, ptr}
ram_wdata  out  DATA_W  write data
ram_raddr  out  SEG_W+2  read address; BRAM dout valid one cycle later
ram_rdata  in  DATA_W  BRAM port B data

Behaviour:
- Reset (async): state IDLE; wr_ptr=0; taps=0; taps_valid=0; busy=0; overrun=0; ram_we=0; ram addresses and data 0; active and pending delays = DLYx_INIT.
- States: IDLE -> RUN (4 cycles, idx 0..3) -> DRAIN (1 cycle) -> DONE (1 cycle) -> IDLE.
- Accept: in IDLE, sample_strobe=1 latches fb_data, copies pending delays to active, and moves to RUN next cycle. busy is high from the cycle after acceptance through DONE.
- RUN idx i, all outputs registered:
  - ram_we=1, ram_waddr={i, wr_ptr}, ram_wdata=fb_latched[i].
  - ram_raddr={i, wr_ptr - active_dly[i]}. The subtraction is modulo 2^SEG_W, so the address wraps inside the segment.
- Capture: ram_rdata presented for idx i is stored into an internal tap register the cycle after its address. Idx 3 is captured in DRAIN.
- DONE: the taps output is updated from all 4 capture registers simultaneously; taps_valid=1; wr_ptr increments, wrapping 2^SEG_W-1 -> 0. The taps output never changes outside DONE.
- Latency: strobe sampled at cycle T -> taps_valid high in cycle T+6. The next strobe is accepted at T+7 or later.
- Tap semantics: the tap for line i equals the fb word written to line i exactly active_dly[i] accepted samples earlier. Read and write addresses never collide because delay >= 1.
- Config:
  - cfg_we writes cfg_delay into pending[cfg_sel].
  - cfg_delay=0 is clamped to 1.
  - cfg_we in the same cycle as acceptance updates pending only; the new value takes effect on the following sample.
  - Delays never change mid-sequence.
- Overrun:
  - sample_strobe while not IDLE is ignored and sets overrun.
  - overrun_clr clears overrun.
  - If set and clear coincide, set wins.
- Reset mid-sequence: aborts immediately; no taps_valid; wr_ptr returns to 0; BRAM contents are untouched.
- Without the clear feature, BRAM contents after reset are undefined; taps are meaningless until each line has been written active_dly times.

Optional Feature:
FDN_SCHED_CLEAR_EN
- Defined: after reset, state CLEAR sweeps all 2^(SEG_W+2) addresses, one per cycle, with ram_we=1 and ram_wdata=0. busy=1 throughout, and strobes during CLEAR set overrun. Afterwards the state goes to IDLE and early taps read as 0.
- Undefined: the CLEAR state and its counter are absent; the block is IDLE directly after reset.

Decomposition:
- Package fdn_pkg holds:
  - constant NLINES=4, DATA_W, SEG_W;
  - the state enum (IDLE, RUN, DRAIN, DONE, CLEAR);
  - line index type (2-bit);
  - default delay constants.
- One natural sub-module: fdn_delay_cfg. It contains the pending/active delay register banks with clamp and the atomic load on accept.

Test Plan:
- Reset, delays 1/1/1/1 via cfg, then strobes with fb_data line i = 0x0100*i+n on sample n -> on sample n, taps equal sample n-1's values (line 2 on sample 5 = 0x0204); taps_valid exactly T+6.
- DLY0_INIT=1153: drive ramp fb line0 = n -> at sample 1200, tap0 = 47; check ram_raddr wrap when wr_ptr < 1153 (e.g. wr_ptr=5 -> raddr {0,12'd2948}).
- wr_ptr wrap: run 4100 samples at delay 3 -> after wr_ptr rolls 4095 -> 0, tap still equals value from 3 samples earlier.
- Second strobe 3 cycles after the first -> ignored, overrun=1, one taps_valid only; overrun_clr coincident with a new overrun -> overrun stays 1.
- cfg_we (sel 2, delay 0) in the same cycle as acceptance -> that sample uses the old delay; the next sample reads with delay 1 (clamp).
- rst_n low during RUN idx 2 -> all outputs 0 asynchronously, no taps_valid; with FDN_SCHED_CLEAR_EN, busy stays high 16384 cycles and the first taps are 0.
